alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
// Execute-stage ALU downstream of the ALU control decoder; consumes the 4-bit ALUsel code plus two operands.
// Registers result and branch flags behind valid/ready handshakes; shifts run serially, 1 bit/cycle.
// Feeds writeback mux and branch-compare logic; upstream stalls on in_ready low.
// PARAMETERS
// XLEN     32   operand/result width; shift amount = b[$clog2(XLEN)-1:0]
// PORTS
// clk        in   1     rising-edge clock
// rst        in   1     asynchronous, active-low reset
// flush      in   1     sync abort: drop in-flight op and held result
// in_valid   in   1     operands/alu_sel valid
// in_ready   out  1     unit can accept this cycle
// alu_sel    in   4     0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SRL, 0110 SUB, 0111 SRA, 1000 SLL, 1101 SLT, 1111 SLTU
// a, b       in   XLEN  operands
// out_valid  out  1     result/flags valid
// out_ready  in   1     consumer takes result
// result     out  XLEN  registered result
// zf,cf,vf,sf out 1 each registered zero/carry/overflow/sign flags
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, out_valid=0, result=0, zf=cf=vf=sf=0, shift counter=0; in_ready=0 while rst=0.
// - States: IDLE (no op, out reg empty), SHIFT (serial shift in progress), HOLD (out_valid=1, awaiting out_ready).
// - in_ready = (state==IDLE) | (state==HOLD & out_ready); never high in SHIFT. Accept = in_valid & in_ready & ~flush.
// - Non-shift op accepted at cycle T -> out_valid=1 at T+1 (state HOLD).
// - Shift op, shamt=b[4:0]: shamt==0 -> HOLD at T+1, result=a. shamt>0 -> SHIFT for shamt cycles, 1 bit/cycle, out_valid at T+1+shamt.
// - SRA fills with a[XLEN-1] captured at accept; SRL/SLL fill with 0. Operands latched at accept; later input changes ignored.
// - ADD/SUB: XLEN+1-bit sum a+b or a+~b+1; cf=bit XLEN (SUB: cf=1 iff a>=b unsigned); vf = signed overflow.
// - SLT: result={31'b0, signed a<b}; SLTU: unsigned; flags of a-b. Logic/shift ops: cf=vf=0.
// - zf=(result==0), sf=result[XLEN-1] for every op, computed on the final registered result.
// - Undefined alu_sel: result=0, zf=1, cf=vf=sf=0, latency 1 (no hang).
// - HOLD: result/flags stable while out_valid & ~out_ready. out_ready with no new accept -> IDLE next cycle.
// - Back-to-back: HOLD & out_ready & in_valid -> new op accepted same cycle, no bubble for 1-cycle ops.
// - flush (sync) in any state: next cycle IDLE, out_valid=0, counter cleared; result/flags keep last value; flush beats in_valid.
// - Reset asserted mid-SHIFT: immediate return to reset values; no partial result emitted.
// CONFIGURATION
// ALU_BARREL_SHIFT_EN defined: shifts computed combinationally at accept; every op latency 1, SHIFT state unused/removed, in_ready never blocked by shifts.
// ALU_BARREL_SHIFT_EN undefined: serial shifter as above, latency 1+shamt for shifts.
// TESTING
// ADD a=0x7FFFFFFF b=1 -> next cycle result=0x80000000, vf=1, sf=1, cf=0, zf=0.
// SUB a=b=0x12345678 -> result=0, zf=1, cf=1, vf=0; SLTU a=1 b=0xFFFFFFFF -> result=1.
// SRA a=0x80000000 b=31 -> in_ready=0 for 31 cycles, out_valid at T+32, result=0xFFFFFFFF (macro on: T+1).
// Backpressure: ADD result held 5 cycles with out_ready=0 -> result/flags unchanged, in_ready=0; out_ready=1 with queued XOR -> accepted same cycle, XOR out next cycle.
// flush at 10th cycle of SLL by 20 -> out_valid stays 0, state IDLE, in_ready=1 next cycle; following ADD 2+3 -> 5.
// rst low mid-SRL then release -> out_valid=0, result=0, flags 0; alu_sel=4'b1010 -> result=0, zf=1 after 1 cycle.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operand/result handshake bundle for the execute-stage ALU
//
// Signals:
//   in_valid, in_ready        operand handshake (decoder -> ALU)
//   alu_sel[3:0], a, b        operation code and operands
//   out_valid, out_ready      result handshake (ALU -> writeback / branch compare)
//   result, zf, cf, vf, sf    registered result and flags
// Modports: master = upstream/downstream environment, slave = the ALU.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zf;
    logic            cf;
    logic            vf;
    logic            sf;

    modport master (
        output in_valid, alu_sel, a, b, out_ready,
        input  in_ready, out_valid, result, zf, cf, vf, sf
    );

    modport slave (
        input  in_valid, alu_sel, a, b, out_ready,
        output in_ready, out_valid, result, zf, cf, vf, sf
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with registered result/flags and serial shifter
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   flush  synchronous abort of the in-flight op and the held result
//   bus    alu_exec_unit_if.slave (operand handshake in, result handshake out)
// Option macro ALU_BARREL_SHIFT_EN: when defined, shifts are computed in one cycle
// at accept and the SHIFT state is never entered; otherwise shifts take 1 bit/cycle.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    alu_exec_unit_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [XLEN-1:0] result_q;
    logic            zf_q, cf_q, vf_q, sf_q;

    logic            in_ready_c;
    logic            accept;
    logic            shift_req;
    logic            shift_done;
    logic            wr_en;
    logic [SHW-1:0]  shamt;
    logic [XLEN:0]   sum_add;
    logic [XLEN:0]   sum_sub;
    logic            add_vf, sub_vf, slt_bit;
    logic [XLEN-1:0] imm_res;
    logic            imm_cf, imm_vf;
    logic [XLEN-1:0] wr_res;
    logic            wr_cf, wr_vf;

    assign shamt = bus.b[SHW-1:0];

    assign in_ready_c = rst & ((state == IDLE) | ((state == HOLD) & bus.out_ready));
    assign accept     = bus.in_valid & in_ready_c & ~flush;

    // Carry out of bit XLEN: for SUB it is the "no borrow" bit, i.e. a >= b unsigned.
    assign sum_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{XLEN{1'b0}}, 1'b1};
    assign add_vf  = (bus.a[XLEN-1] == bus.b[XLEN-1]) & (sum_add[XLEN-1] != bus.a[XLEN-1]);
    assign sub_vf  = (bus.a[XLEN-1] != bus.b[XLEN-1]) & (sum_sub[XLEN-1] != bus.a[XLEN-1]);
    assign slt_bit = sum_sub[XLEN-1] ^ sub_vf;

    // Single-cycle result for everything that completes on the accept edge.
    always_comb begin
        imm_res = '0;
        imm_cf  = 1'b0;
        imm_vf  = 1'b0;
        case (bus.alu_sel)
            OP_AND:  imm_res = bus.a & bus.b;
            OP_OR:   imm_res = bus.a | bus.b;
            OP_XOR:  imm_res = bus.a ^ bus.b;
            OP_ADD: begin
                imm_res = sum_add[XLEN-1:0];
                imm_cf  = sum_add[XLEN];
                imm_vf  = add_vf;
            end
            OP_SUB: begin
                imm_res = sum_sub[XLEN-1:0];
                imm_cf  = sum_sub[XLEN];
                imm_vf  = sub_vf;
            end
            OP_SLT: begin
                imm_res = {{(XLEN-1){1'b0}}, slt_bit};
                imm_cf  = sum_sub[XLEN];
                imm_vf  = sub_vf;
            end
            OP_SLTU: begin
                imm_res = {{(XLEN-1){1'b0}}, ~sum_sub[XLEN]};
                imm_cf  = sum_sub[XLEN];
                imm_vf  = sub_vf;
            end
`ifdef ALU_BARREL_SHIFT_EN
            OP_SRL:  imm_res = bus.a >> shamt;
            OP_SLL:  imm_res = bus.a << shamt;
            OP_SRA:  imm_res = XLEN'($signed(bus.a) >>> shamt);
`else
            // Only reaches the result register when shamt == 0.
            OP_SRL, OP_SLL, OP_SRA: imm_res = bus.a;
`endif
            default: imm_res = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign shift_req  = 1'b0;
    assign shift_done = 1'b0;
    assign wr_res     = imm_res;
    assign wr_cf      = imm_cf;
    assign wr_vf      = imm_vf;
`else
    logic [XLEN-1:0] sh_val, sh_next;
    logic [SHW-1:0]  sh_cnt;
    logic [3:0]      sh_op;
    logic            is_shift;

    assign is_shift   = (bus.alu_sel == OP_SRL) | (bus.alu_sel == OP_SRA) | (bus.alu_sel == OP_SLL);
    assign shift_req  = is_shift & (shamt != '0);
    assign shift_done = (state == SHIFT) & (sh_cnt == SHW'(1)) & ~flush;

    // SRA keeps replicating the latched MSB, which is a[XLEN-1] from accept time.
    always_comb begin
        case (sh_op)
            OP_SLL:  sh_next = {sh_val[XLEN-2:0], 1'b0};
            OP_SRA:  sh_next = {sh_val[XLEN-1], sh_val[XLEN-1:1]};
            default: sh_next = {1'b0, sh_val[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_val <= '0;
            sh_cnt <= '0;
            sh_op  <= '0;
        end else if (flush) begin
            sh_cnt <= '0;
        end else if (accept && shift_req) begin
            sh_val <= bus.a;
            sh_cnt <= shamt;
            sh_op  <= bus.alu_sel;
        end else if (state == SHIFT) begin
            sh_val <= sh_next;
            sh_cnt <= sh_cnt - 1'b1;
        end
    end

    assign wr_res = shift_done ? sh_next : imm_res;
    assign wr_cf  = shift_done ? 1'b0    : imm_cf;
    assign wr_vf  = shift_done ? 1'b0    : imm_vf;
`endif

    assign wr_en = (accept & ~shift_req) | shift_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    state_n = shift_req ? SHIFT : HOLD;
                end else if (state == HOLD && bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (shift_done) begin
                    state_n = HOLD;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
        end
    end

    // Result/flags only change on a completing op; flush leaves them untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            vf_q     <= 1'b0;
            sf_q     <= 1'b0;
        end else if (wr_en) begin
            result_q <= wr_res;
            zf_q     <= (wr_res == '0);
            cf_q     <= wr_cf;
            vf_q     <= wr_vf;
            sf_q     <= wr_res[XLEN-1];
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == HOLD);
    assign bus.result    = result_q;
    assign bus.zf        = zf_q;
    assign bus.cf        = cf_q;
    assign bus.vf        = vf_q;
    assign bus.sf        = sf_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_exec_unit_if #(.XLEN(32)) bus();
    alu_exec_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        zf, cf, vf, sf;
        int          due;
    } exp_t;

    exp_t q[$];

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, ua, ub, d;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sh = int'(b[4:0]);
        e.res = 32'h0;
        e.cf  = 1'b0;
        e.vf  = 1'b0;
        e.due = 0;
        case (sel)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_XOR: e.res = a ^ b;
            OP_ADD: begin
                e.res = a + b;
                e.cf  = (ua + ub) > 64'd4294967295;
                d     = sa + sb;
                e.vf  = (d > SMAX) || (d < SMIN);
            end
            OP_SUB, OP_SLT, OP_SLTU: begin
                e.cf = (ua >= ub);
                d    = sa - sb;
                e.vf = (d > SMAX) || (d < SMIN);
                if (sel == OP_SUB)      e.res = a - b;
                else if (sel == OP_SLT) e.res = (sa < sb) ? 32'd1 : 32'd0;
                else                    e.res = (ua < ub) ? 32'd1 : 32'd0;
            end
            OP_SRL: e.res = a >> sh;
            OP_SLL: e.res = a << sh;
            OP_SRA: e.res = 32'($signed(a) >>> sh);
            default: e.res = 32'h0;
        endcase
        e.zf = (e.res == 32'h0);
        e.sf = e.res[31];
        return e;
    endfunction

    // Inputs change 1ns after a rising edge; outputs sampled on falling edges.
    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        int   guard;
        e   = model(sel, a, b);
        lat = 1;
`ifndef ALU_BARREL_SHIFT_EN
        if (sel == OP_SRL || sel == OP_SRA || sel == OP_SLL) lat = 1 + int'(b[4:0]);
`endif
        bus.in_valid = 1'b1;
        bus.alu_sel  = sel;
        bus.a        = a;
        bus.b        = b;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            chk_eq("accept_timeout", {31'h0, bus.in_ready}, 32'h1);
        end else begin
            e.due = cyc + lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < max) begin
            n++;
            @(negedge clk);
        end
        if (!bus.out_valid) chk_eq("out_valid_timeout", {31'h0, bus.out_valid}, 32'h1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        issue(sel, a, b);
        wait_valid(64);
        step();
    endtask

    // Scoreboard: every cycle with out_valid is compared against the queue head.
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                seen = 1'b0;
                continue;
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk_eq("out_valid_unexpected", {31'h0, bus.out_valid}, 32'h0);
                end else begin
                    if (!seen) begin
                        chk_eq("latency", cyc, q[0].due);
                        seen = 1'b1;
                    end
                    chk_eq("sb_result", bus.result, q[0].res);
                    chk_eq("sb_flags", {28'h0, bus.zf, bus.cf, bus.vf, bus.sf},
                           {28'h0, q[0].zf, q[0].cf, q[0].vf, q[0].sf});
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus.in_valid  = 1'b0;
        bus.alu_sel   = 4'h0;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk_eq("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk_eq("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk_eq("rst_result", bus.result, 32'h0);
        chk_eq("rst_flags", {28'h0, bus.zf, bus.cf, bus.vf, bus.sf}, 32'h0);
        step();
        rst = 1'b1;

        // Pin the model to hand-computed values
        e = model(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        chk_eq("pin_add_res", e.res, 32'h8000_0000);
        chk_eq("pin_add_flags", {28'h0, e.zf, e.cf, e.vf, e.sf}, 32'h3);
        e = model(OP_SUB, 32'h1234_5678, 32'h1234_5678);
        chk_eq("pin_sub_flags", {28'h0, e.zf, e.cf, e.vf, e.sf}, 32'hC);
        e = model(OP_SLTU, 32'h1, 32'hFFFF_FFFF);
        chk_eq("pin_sltu_res", e.res, 32'h1);
        e = model(OP_SRA, 32'h8000_0000, 32'd31);
        chk_eq("pin_sra_res", e.res, 32'hFFFF_FFFF);

        step();
        chk_eq("idle_in_ready", {31'h0, bus.in_ready}, 32'h1);

        // ADD overflow
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_valid(4);
        chk_eq("add_ovf_result", bus.result, 32'h8000_0000);
        chk_eq("add_ovf_flags", {28'h0, bus.zf, bus.cf, bus.vf, bus.sf}, 32'h3);
        step();

        // SUB equal operands
        issue(OP_SUB, 32'h1234_5678, 32'h1234_5678);
        wait_valid(4);
        chk_eq("sub_eq_result", bus.result, 32'h0);
        chk_eq("sub_eq_flags", {28'h0, bus.zf, bus.cf, bus.vf, bus.sf}, 32'hC);
        step();

        // SLTU with all-ones b
        issue(OP_SLTU, 32'h1, 32'hFFFF_FFFF);
        wait_valid(4);
        chk_eq("sltu_result", bus.result, 32'h1);
        step();

        run(OP_SLT, 32'hFFFF_FFFB, 32'h3);
        run(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
        run(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        run(OP_SUB, 32'h0000_0001, 32'h0000_0002);
        run(OP_SRL, 32'hF000_0000, 32'h4);
        run(OP_SLL, 32'h0000_1234, 32'h20);

        // SRA by 31: long serial shift, operand inputs scrambled after accept
        issue(OP_SRA, 32'h8000_0000, 32'd31);
`ifndef ALU_BARREL_SHIFT_EN
        repeat (3) begin
            @(negedge clk);
            chk_eq("sra_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
        end
`endif
        wait_valid(40);
        chk_eq("sra_result", bus.result, 32'hFFFF_FFFF);
        step();

        // Backpressure then back-to-back XOR
        bus.out_ready = 1'b0;
        issue(OP_ADD, 32'h0000_1000, 32'h0000_0234);
        repeat (5) begin
            @(negedge clk);
            chk_eq("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
            chk_eq("bp_result", bus.result, 32'h0000_1234);
            chk_eq("bp_flags", {28'h0, bus.zf, bus.cf, bus.vf, bus.sf}, 32'h0);
        end
        step();
        bus.out_ready = 1'b1;
        issue(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        wait_valid(4);
        chk_eq("b2b_xor_result", bus.result, 32'hF00F_F00F);
        step();

        run(OP_OR, 32'h0000_00F0, 32'h0000_0F00);

        // flush on the 10th cycle of SLL by 20
        issue(OP_SLL, 32'h1, 32'd20);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        q.delete();
        @(negedge clk);
        chk_eq("flush_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk_eq("flush_in_ready", {31'h0, bus.in_ready}, 32'h1);
`ifdef ALU_BARREL_SHIFT_EN
        chk_eq("flush_keeps_result", bus.result, 32'h0010_0000);
`else
        chk_eq("flush_keeps_result", bus.result, 32'h0000_0FF0);
`endif
        repeat (25) @(negedge clk);
        step();
        issue(OP_ADD, 32'd2, 32'd3);
        wait_valid(4);
        chk_eq("post_flush_add", bus.result, 32'd5);
        step();

        // Reset in the middle of SRL
        issue(OP_SRL, 32'hDEAD_BEEF, 32'd20);
        repeat (5) step();
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk_eq("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk_eq("midrst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk_eq("midrst_result", bus.result, 32'h0);
        chk_eq("midrst_flags", {28'h0, bus.zf, bus.cf, bus.vf, bus.sf}, 32'h0);
        step();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("midrst_no_partial", {31'h0, bus.out_valid}, 32'h0);
        step();

        // Undefined opcode
        issue(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_valid(4);
        chk_eq("undef_result", bus.result, 32'h0);
        chk_eq("undef_flags", {28'h0, bus.zf, bus.cf, bus.vf, bus.sf}, 32'h8);
        step();

        repeat (3) @(negedge clk);
        chk_eq("queue_drained", q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
